// File: rtl/vedic_dot_accum.sv
// Dot-product accumulator: sums N_TERMS consecutive unsigned products from the
// Vedic multiplier into one result, with valid/ready handshakes on both sides.
module vedic_dot_accum #(
   parameter int PROD_W  = 16,
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [PROD_W-1:0] prod,
   input  logic              prod_valid,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  sum,
   output logic              sum_ovf,
   output logic              sum_valid,
   input  logic              sum_ready
);

   localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t           state;
   state_t           state_next;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic             accept;
   logic             last_term;
   logic [ACC_W:0]   acc_sum;

   // One extra bit on the adder captures the carry out of the accumulator width.
   assign acc_sum   = {1'b0, acc} + {{(ACC_W - PROD_W + 1){1'b0}}, prod};
   assign last_term = (cnt == LAST_CNT);
   assign accept    = prod_valid && prod_ready;

   always_comb begin
      state_next = state;
      prod_ready = 1'b0;
      case (state)
         ACCUM: begin
            prod_ready = 1'b1;
            if (prod_valid && !clr && last_term)
               state_next = HOLD;
         end
         HOLD: begin
            if (sum_ready)
               state_next = ACCUM;
         end
         default: state_next = ACCUM;
      endcase
   end

   // A product accepted while clr is high completes the handshake but is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         sum       <= '0;
         sum_ovf   <= 1'b0;
         sum_valid <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            ACCUM: begin
               if (clr) begin
                  acc <= '0;
                  cnt <= '0;
                  ovf <= 1'b0;
               end else if (accept) begin
                  if (last_term) begin
                     sum       <= acc_sum[ACC_W-1:0];
                     sum_ovf   <= ovf | acc_sum[ACC_W];
                     sum_valid <= 1'b1;
                     acc       <= '0;
                     cnt       <= '0;
                     ovf       <= 1'b0;
                  end else begin
                     acc <= acc_sum[ACC_W-1:0];
                     cnt <= cnt + CNT_W'(1);
                     ovf <= ovf | acc_sum[ACC_W];
                  end
               end
            end
            HOLD: begin
               if (sum_ready)
                  sum_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vedic_dot_accum.sv
// Self-checking bench for vedic_dot_accum: an 18-bit and a 17-bit accumulator
// share one stimulus stream and are compared against a frame-sum reference model.
module tb_vedic_dot_accum;

   localparam int N_TERMS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [15:0] prod;
   logic        prod_valid;
   logic        sum_ready;

   logic        pr18, o18, v18;
   logic [17:0] s18;
   logic        pr17, o17, v17;
   logic [16:0] s17;

   int assert_count = 0;
   int fail_count   = 0;

   // Reference model: products of the current frame and the expected held result.
   int unsigned terms[$];
   logic        m_valid;
   longint unsigned m_sum18, m_sum17;
   logic        m_ovf18, m_ovf17;

   always #5 clk = ~clk;

   vedic_dot_accum #(.PROD_W(16), .N_TERMS(N_TERMS), .ACC_W(18)) dut (
      .clk(clk), .rst(rst), .clr(clr), .prod(prod), .prod_valid(prod_valid),
      .prod_ready(pr18), .sum(s18), .sum_ovf(o18), .sum_valid(v18), .sum_ready(sum_ready)
   );

   vedic_dot_accum #(.PROD_W(16), .N_TERMS(N_TERMS), .ACC_W(17)) dut17 (
      .clk(clk), .rst(rst), .clr(clr), .prod(prod), .prod_valid(prod_valid),
      .prod_ready(pr17), .sum(s17), .sum_ovf(o17), .sum_valid(v17), .sum_ready(sum_ready)
   );

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      assert_count++;
      assert (got === exp) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic checkOutput();
      check("prod_ready18", 64'(pr18), 64'(!m_valid));
      check("sum_valid18",  64'(v18),  64'(m_valid));
      check("sum18",        64'(s18),  m_sum18);
      check("prod_ready17", 64'(pr17), 64'(!m_valid));
      check("sum_valid17",  64'(v17),  64'(m_valid));
      check("sum17",        64'(s17),  m_sum17);
      if (m_valid) begin
         check("sum_ovf18", 64'(o18), 64'(m_ovf18));
         check("sum_ovf17", 64'(o17), 64'(m_ovf17));
      end
   endtask

   // Update the model from the inputs presented this cycle, clock once, then compare.
   task automatic applyStimulus();
      longint unsigned total;
      if (rst) begin
         terms.delete();
         m_valid = 1'b0;
         m_sum18 = 0;
         m_sum17 = 0;
         m_ovf18 = 1'b0;
         m_ovf17 = 1'b0;
      end else if (!m_valid) begin
         if (clr) begin
            terms.delete();
         end else if (prod_valid) begin
            terms.push_back(32'(prod));
            if (terms.size() == N_TERMS) begin
               total = 0;
               foreach (terms[i]) total += terms[i];
               m_sum18 = total % (64'd1 << 18);
               m_ovf18 = (total >= (64'd1 << 18));
               m_sum17 = total % (64'd1 << 17);
               m_ovf17 = (total >= (64'd1 << 17));
               m_valid = 1'b1;
               terms.delete();
            end
         end
      end else if (sum_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic drive(input logic r, input logic c, input logic [15:0] p,
                        input logic pv, input logic sr);
      rst        = r;
      clr        = c;
      prod       = p;
      prod_valid = pv;
      sum_ready  = sr;
      applyStimulus();
   endtask

   initial begin
      m_valid = 1'b0;
      m_sum18 = 0;
      m_sum17 = 0;
      m_ovf18 = 1'b0;
      m_ovf17 = 1'b0;
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      check("reset_sum_valid", 64'(v18), 0);
      check("reset_prod_ready", 64'(pr18), 1);

      // Back-to-back frame 15,8,4,4
      drive(0, 0, 15, 1, 1);
      drive(0, 0, 8, 1, 1);
      drive(0, 0, 4, 1, 1);
      check("t1_no_early_valid", 64'(v18), 0);
      drive(0, 0, 4, 1, 1);
      check("t1_sum", 64'(s18), 31);
      check("t1_ovf", 64'(o18), 0);
      drive(0, 0, 0, 0, 1);

      // Maximum products: fits in 18 bits, overflows 17 bits
      for (int i = 0; i < 4; i++) drive(0, 0, 16'd65025, 1, 0);
      check("t2_sum18", 64'(s18), 260100);
      check("t2_ovf18", 64'(o18), 0);
      check("t2_sum17", 64'(s17), 129028);
      check("t2_ovf17", 64'(o17), 1);
      drive(0, 0, 0, 0, 1);

      // Backpressure: result held while the sink stalls
      for (int i = 0; i < 4; i++) drive(0, 0, 7, 1, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 16'd500, 1, 0);
         check("t3_stall_ready", 64'(pr18), 0);
         check("t3_stall_sum", 64'(s18), 28);
      end
      drive(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 0);
      check("t3_sum", 64'(s18), 4);
      drive(0, 0, 0, 0, 1);

      // Gapped input
      drive(0, 0, 6, 1, 0);  drive(0, 0, 9, 0, 0);
      drive(0, 0, 48, 1, 0); drive(0, 0, 9, 0, 0);
      drive(0, 0, 2, 1, 0);  drive(0, 0, 9, 0, 0);
      drive(0, 0, 2, 1, 0);
      check("t4_sum", 64'(s18), 58);
      drive(0, 0, 0, 0, 1);

      // Reset mid-frame
      drive(0, 0, 100, 1, 0);
      drive(0, 0, 200, 1, 0);
      drive(1, 0, 0, 0, 0);
      check("t5_rst_valid", 64'(v18), 0);
      for (int i = 1; i <= 4; i++) drive(0, 0, 16'(i), 1, 0);
      check("t5_sum", 64'(s18), 10);
      drive(0, 0, 0, 0, 1);

      // clr drops the partial sum and the product presented with it
      drive(0, 0, 7, 1, 0);
      drive(0, 0, 8, 1, 0);
      drive(0, 1, 999, 1, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 5, 1, 0);
      check("t6_sum", 64'(s18), 20);
      drive(0, 1, 0, 0, 0);
      check("t6_hold_clr", 64'(s18), 20);
      check("t6_hold_valid", 64'(v18), 1);
      drive(0, 0, 0, 0, 1);

      // Randomized traffic with occasional clr and rst
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
               16'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
